// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: privilege modes, CSR addresses, cause codes and trap FSM states
package trap_ctrl_pkg;
  typedef enum logic [1:0] {
    U_MODE = 2'd0,
    S_MODE = 2'd1,
    H_MODE = 2'd2,
    M_MODE = 2'd3
  } mode_e;
  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } trap_state_e;
  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_SIE      = 12'h104;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_SIP      = 12'h144;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MIDELEG  = 12'h303;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] CAUSE_MSI           = 4'd3;
  localparam logic [3:0] CAUSE_MTI           = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_U       = 4'd8;
  localparam logic [3:0] CAUSE_MEI           = 4'd11;
  function automatic logic irq_enabled(input logic deleg, input logic [1:0] mode,
                                       input logic m_ie, input logic s_ie);
    return (deleg && mode <= S_MODE) ? (mode == U_MODE || s_ie) : (mode != M_MODE || m_ie);
  endfunction
endpackage

// File: rtl/trap_ctrl_irq_select.sv
// irq_select: picks the highest-priority pending, enabled interrupt and its target mode
module irq_select
  import trap_ctrl_pkg::*;
(
  input  logic [2:0] pend,
  input  logic [2:0] deleg,
  input  logic [1:0] mode,
  input  logic       m_ie,
  input  logic       s_ie,
  output logic       valid,
  output logic [3:0] code,
  output logic       to_s
);
  // bit order in pend/deleg is priority order: {MTI, MSI, MEI}
  logic [2:0] hit;
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) hit[i] = pend[i] && irq_enabled(deleg[i], mode, m_ie, s_ie);
  end
  assign valid = |hit;
  assign code  = hit[0] ? CAUSE_MEI : hit[1] ? CAUSE_MSI : CAUSE_MTI;
  assign to_s  = (hit[0] ? deleg[0] : hit[1] ? deleg[1] : deleg[2]) && mode <= S_MODE;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/xRET sequencing, privilege mode and M/S trap CSRs
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            ret_valid,
  input  logic            ret_is_mret,
  input  logic            boundary,
  input  logic [XLEN-1:0] boundary_pc,
  input  logic            mtip,
  input  logic            msip,
  input  logic            meip,
  input  logic [11:0]     csr_addr,
  input  logic            csr_wen,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic [1:0]      mode,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
);
  localparam logic [XLEN-1:0] IRQ_MASK     = XLEN'(12'h888);
  localparam logic [XLEN-1:0] SSTATUS_MASK = XLEN'(12'h122);
  trap_state_e state;
  logic m_ie, s_ie, m_pie, s_pie, spp;
  logic [1:0] mpp;
  logic [15:0] medeleg;
  logic [XLEN-1:0] mtvec, stvec, mepc, sepc, mcause, scause, mtval, stval;
  logic [XLEN-1:0] mie, mideleg, mscratch, sscratch, mstatus, mip;
  logic irq_valid, irq_to_s, ret_ok, take_exc, take_ret, take_irq, t_to_s;
  logic [3:0] irq_code, t_code;
  logic [XLEN-1:0] t_pc, t_tval, t_cause, t_vec, t_base, t_target;
  always_comb begin
    mstatus = '0;
    mstatus[1] = s_ie;
    mstatus[3] = m_ie;
    mstatus[5] = s_pie;
    mstatus[7] = m_pie;
    mstatus[8] = spp;
    mstatus[12:11] = mpp;
    mip = '0;
    mip[3] = msip;
    mip[7] = mtip;
    mip[11] = meip;
  end
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus;
      CSR_SSTATUS:  csr_rdata = mstatus & SSTATUS_MASK;
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_STVEC:    csr_rdata = stvec;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_SEPC:     csr_rdata = sepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_SCAUSE:   csr_rdata = scause;
      CSR_MTVAL:    csr_rdata = mtval;
      CSR_STVAL:    csr_rdata = stval;
      CSR_MEDELEG:  csr_rdata = {{(XLEN-16){1'b0}}, medeleg};
      CSR_MIDELEG:  csr_rdata = mideleg;
      CSR_MIE:      csr_rdata = mie;
      CSR_SIE:      csr_rdata = mie & mideleg;
      CSR_MIP:      csr_rdata = mip;
      CSR_SIP:      csr_rdata = mip & mideleg;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_SSCRATCH: csr_rdata = sscratch;
      default:      csr_rdata = '0;
    endcase
  end
  irq_select u_irq_select (
    .pend  ({mtip & mie[7], msip & mie[3], meip & mie[11]}),
    .deleg ({mideleg[7], mideleg[3], mideleg[11]}),
    .mode  (mode),
    .m_ie  (m_ie),
    .s_ie  (s_ie),
    .valid (irq_valid),
    .code  (irq_code),
    .to_s  (irq_to_s)
  );
  // an xRET from too low a privilege becomes an illegal-instruction trap at exc_pc
  assign ret_ok   = ret_is_mret ? mode == M_MODE : mode >= S_MODE;
  assign take_exc = state == IDLE && (exc_valid || (ret_valid && !ret_ok));
  assign take_ret = state == IDLE && !exc_valid && ret_valid && ret_ok;
  assign take_irq = state == IDLE && !exc_valid && !ret_valid && boundary && irq_valid;
  assign t_code   = take_irq ? irq_code : exc_valid ? exc_code : CAUSE_ILLEGAL_INSTR;
  assign t_to_s   = take_irq ? irq_to_s : mode <= S_MODE && medeleg[t_code];
  assign t_pc     = take_irq ? boundary_pc : exc_pc;
  assign t_tval   = take_exc && exc_valid ? exc_tval : '0;
  assign t_cause  = {take_irq, {(XLEN-5){1'b0}}, t_code};
  assign t_vec    = t_to_s ? stvec : mtvec;
  assign t_base   = {t_vec[XLEN-1:2], 2'b00};
  assign t_target = take_irq && t_vec[1:0] == 2'b01 ? t_base + {{(XLEN-6){1'b0}}, t_code, 2'b00} : t_base;
  assign redirect_valid = state == REDIRECT;
  assign busy = state == REDIRECT;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mode <= M_MODE;
      redirect_pc <= '0;
      {m_ie, s_ie, m_pie, s_pie, spp, mpp} <= '0;
      medeleg <= '0;
      {mtvec, stvec, mepc, sepc, mcause, scause, mtval, stval} <= '0;
      {mie, mideleg, mscratch, sscratch} <= '0;
    end else if (state == REDIRECT) begin
      if (redirect_ready) state <= IDLE;
    end else if (take_exc || take_irq) begin
      state <= REDIRECT;
      redirect_pc <= t_target;
      if (t_to_s) begin
        sepc <= {t_pc[XLEN-1:1], 1'b0};
        scause <= t_cause;
        stval <= t_tval;
        s_pie <= s_ie;
        s_ie <= 1'b0;
        spp <= mode[0];
        mode <= S_MODE;
      end else begin
        mepc <= {t_pc[XLEN-1:1], 1'b0};
        mcause <= t_cause;
        mtval <= t_tval;
        m_pie <= m_ie;
        m_ie <= 1'b0;
        mpp <= mode;
        mode <= M_MODE;
      end
    end else if (take_ret) begin
      state <= REDIRECT;
      if (ret_is_mret) begin
        redirect_pc <= mepc;
        mode <= mpp;
        m_ie <= m_pie;
        m_pie <= 1'b1;
        mpp <= U_MODE;
      end else begin
        redirect_pc <= sepc;
        mode <= {1'b0, spp};
        s_ie <= s_pie;
        s_pie <= 1'b1;
        spp <= 1'b0;
      end
    end else if (csr_wen) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          {s_ie, m_ie, s_pie, m_pie, spp} <= {csr_wdata[1], csr_wdata[3], csr_wdata[5], csr_wdata[7], csr_wdata[8]};
          mpp <= csr_wdata[12:11] == H_MODE ? mpp : csr_wdata[12:11];
        end
        CSR_SSTATUS:  {s_ie, s_pie, spp} <= {csr_wdata[1], csr_wdata[5], csr_wdata[8]};
        CSR_MTVEC:    mtvec <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
        CSR_STVEC:    stvec <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
        CSR_MEPC:     mepc <= {csr_wdata[XLEN-1:2], 2'b00};
        CSR_SEPC:     sepc <= {csr_wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause <= csr_wdata;
        CSR_SCAUSE:   scause <= csr_wdata;
        CSR_MTVAL:    mtval <= csr_wdata;
        CSR_STVAL:    stval <= csr_wdata;
        CSR_MEDELEG:  medeleg <= csr_wdata[15:0];
        CSR_MIDELEG:  mideleg <= csr_wdata & IRQ_MASK;
        CSR_MIE:      mie <= csr_wdata & IRQ_MASK;
        CSR_SIE:      mie <= (mie & ~mideleg) | (csr_wdata & mideleg);
        CSR_MSCRATCH: mscratch <= csr_wdata;
        CSR_SSCRATCH: sscratch <= csr_wdata;
        default: ;
      endcase
    end
  end
endmodule
